// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-access controller.
package spi_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_DISPATCH,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_PUSH
  } ctrl_state_t;

  // How the next RX byte of the current frame is interpreted.
  typedef enum logic [1:0] {
    MODE_CMD,
    MODE_READ,
    MODE_WRITE
  } cmd_mode_t;

  // Command byte layout: bit7 selects read, bits[6:0] give the start address.
  localparam int CMD_RD_BIT = 7;

  function automatic logic [6:0] cmd_addr(input logic [7:0] cmd);
    return cmd[6:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset value.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments keep the two stages as separate flops;
      // blocking here would collapse them into one and defeat the synchroniser.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_access_ctrl.sv
// Command sequencer between the SPI slave RX/TX FIFOs and the register bus.
// Each frame starts with a command byte (bit7 = read, bits[6:0] = address);
// the following bytes are burst write data or read dummies with auto-increment.
// Optional: define SPI_REG_CTRL_ERR_CNT_EN to add the err_cnt output.
module spi_reg_access_ctrl
  import spi_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [WIDTH-1:0]  rx_data,
  input  logic              rx_empty,
  output logic              rx_rd_en,
  output logic [WIDTH-1:0]  tx_data,
  input  logic              tx_full,
  output logic              tx_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [WIDTH-1:0]  reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [WIDTH-1:0]  reg_rdata,
  output logic              busy
`ifdef SPI_REG_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  ctrl_state_t       state_q, state_d;
  cmd_mode_t         mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  byte_q, byte_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              cs_sync;
  logic              lat_done;
  logic              frame_close;

  sync_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cs_n),
    .q_o   (cs_sync)
  );

  assign lat_done    = (lat_q == LAT_W'(RD_LAT - 1));
  // A frame end is only honoured once all of its bytes have been consumed.
  assign frame_close = (state_q == ST_IDLE) && rx_empty && cs_sync;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (!rx_empty) state_d = ST_POP;
      ST_POP:      state_d = ST_WAIT;
      ST_WAIT:     if (lat_done) state_d = ST_DISPATCH;
      ST_DISPATCH: begin
        if (mode_q == MODE_CMD)        state_d = byte_q[CMD_RD_BIT] ? ST_RD_REQ : ST_IDLE;
        else if (mode_q == MODE_WRITE) state_d = ST_IDLE;
        else                           state_d = ST_RD_REQ;
      end
      ST_RD_REQ:   state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (lat_done) state_d = ST_PUSH;
      ST_PUSH:     if (!tx_full) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: mode, address counter, captured bytes, latency count.
  always_comb begin
    mode_d = mode_q;
    addr_d = addr_q;
    byte_d = byte_q;
    tx_d   = tx_q;
    lat_d  = '0;
    unique case (state_q)
      ST_IDLE: if (frame_close) mode_d = MODE_CMD;
      ST_WAIT: begin
        if (lat_done) byte_d = rx_data;
        else          lat_d  = lat_q + 1'b1;
      end
      ST_DISPATCH: begin
        if (mode_q == MODE_CMD) begin
          addr_d = cmd_addr(byte_q);
          mode_d = byte_q[CMD_RD_BIT] ? MODE_READ : MODE_WRITE;
        end else if (mode_q == MODE_WRITE) begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_RD_REQ: addr_d = addr_q + 1'b1;
      ST_RD_WAIT: begin
        if (lat_done) tx_d  = reg_rdata;
        else          lat_d = lat_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_CMD;
      addr_q <= '0;
      byte_q <= '0;
      tx_q   <= '0;
      lat_q  <= '0;
    end else begin
      mode_q <= mode_d;
      addr_q <= addr_d;
      byte_q <= byte_d;
      tx_q   <= tx_d;
      lat_q  <= lat_d;
    end
  end

  // Outputs decoded from the current state; strobes are single-cycle by construction.
  always_comb begin
    rx_rd_en  = (state_q == ST_POP);
    reg_we    = (state_q == ST_DISPATCH) && (mode_q == MODE_WRITE);
    reg_re    = (state_q == ST_RD_REQ);
    tx_wr_en  = (state_q == ST_PUSH) && !tx_full;
    reg_addr  = addr_q;
    reg_wdata = byte_q;
    tx_data   = tx_q;
    busy      = (state_q != ST_IDLE) || !cs_sync || (mode_q != MODE_CMD);
  end

`ifdef SPI_REG_CTRL_ERR_CNT_EN
  logic       push_entry_q;
  logic       data_seen_q;
  logic       stall_evt;
  logic       empty_frame_evt;
  logic [7:0] err_cnt_q;

  assign stall_evt       = (state_q == ST_PUSH) && push_entry_q && tx_full;
  assign empty_frame_evt = frame_close && (mode_q != MODE_CMD) && !data_seen_q;

  // Error bookkeeping: PUSH entry flag, data-byte seen flag, saturating counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_entry_q <= 1'b0;
      data_seen_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      push_entry_q <= (state_d == ST_PUSH) && (state_q != ST_PUSH);
      if (frame_close)
        data_seen_q <= 1'b0;
      else if ((state_q == ST_DISPATCH) && (mode_q != MODE_CMD))
        data_seen_q <= 1'b1;
      if ((stall_evt || empty_frame_evt) && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
